// File: rtl/regfile_mp_if.sv
// regfile_mp_if: request/response bundle for the multi-port register file.
//   master : CPU datapath side (drives addresses, write ports, scoreboard set, clear request)
//   slave  : register file side (returns read data, pending flags, clear-busy)
// Signals:
//   rd_addr/rd_data/rd_busy   packed read ports, port k at [k*W +: W]
//   wr0_*                     ALU writeback port
//   wr1_*                     late writeback port, also retires a pending mark
//   sb_set_en/sb_set_addr     mark a register as awaiting a late write
//   clr_req/clr_busy          start / progress of the sequenced clear sweep
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           sb_set_en, sb_set_addr, clr_req,
    input  rd_data, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           sb_set_en, sb_set_addr, clr_req,
    output rd_data, rd_busy, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD combinational read
// ports, two write ports (port 1 wins on a same-address collision), a
// per-register pending scoreboard and a one-register-per-cycle clear sweep.
// Register 0 always reads zero.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears storage, scoreboard and FSM
//   bus    regfile_mp_if.slave bundle (read ports, write ports, scoreboard
//          set, clear request/busy)
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of a register being written in
//                      the same cycle returns the write data combinationally
//                      (port 1 data preferred) and a port-1 write hides the
//                      pending flag. Disabled by default: reads show only the
//                      stored pre-edge state.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clrState_t;

  clrState_t         state;
  logic [ADDR_W-1:0] sweepIdx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic [ADDR_W-1:0] rdAddrK [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdDataS;
  logic [NUM_RD-1:0]        rdBusyS;

  logic wr0Hit;
  logic wr1Hit;
  logic sbHit;

  assign wr0Hit = bus.wr0_en    && (bus.wr0_addr    != ZERO_ADDR);
  assign wr1Hit = bus.wr1_en    && (bus.wr1_addr    != ZERO_ADDR);
  assign sbHit  = bus.sb_set_en && (bus.sb_set_addr != ZERO_ADDR);

  // Clear FSM together with storage and scoreboard updates. Writes and
  // scoreboard requests are only honoured in IDLE; the sweep discards them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sweepIdx <= ZERO_ADDR;
      pending  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state)
        IDLE: begin
          // Port 1 is assigned last so it wins a same-address collision.
          if (wr0Hit) begin
            regs[bus.wr0_addr] <= bus.wr0_data;
          end
          if (wr1Hit) begin
            regs[bus.wr1_addr] <= bus.wr1_data;
          end
          if (bus.clr_req) begin
            state    <= SWEEP;
            sweepIdx <= ADDR_W'(1);
            pending  <= {DEPTH{1'b0}};
          end else begin
            // Clear first, then set, so a simultaneous set wins.
            if (wr1Hit) begin
              pending[bus.wr1_addr] <= 1'b0;
            end
            if (sbHit) begin
              pending[bus.sb_set_addr] <= 1'b1;
            end
          end
        end
        SWEEP: begin
          regs[sweepIdx] <= {DATA_W{1'b0}};
          if (sweepIdx == LAST_ADDR) begin
            state    <= IDLE;
            sweepIdx <= ZERO_ADDR;
          end else begin
            sweepIdx <= sweepIdx + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          sweepIdx <= ZERO_ADDR;
        end
      endcase
    end
  end

  // Unpack the flat read-address bus into one address per port.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rdAddrK[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Combinational read ports: r0 and the whole file read as zero and idle
  // while the sweep runs, so partially cleared contents are never exposed.
  always_comb begin
    rdDataS = {(NUM_RD*DATA_W){1'b0}};
    rdBusyS = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if ((state == SWEEP) || (rdAddrK[k] == ZERO_ADDR)) begin
        rdDataS[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rdBusyS[k]                  = 1'b0;
      end else begin
        rdDataS[k*DATA_W +: DATA_W] = regs[rdAddrK[k]];
        rdBusyS[k]                  = pending[rdAddrK[k]];
`ifdef REGFILE_BYPASS_EN
        if (wr1Hit && (bus.wr1_addr == rdAddrK[k])) begin
          rdDataS[k*DATA_W +: DATA_W] = bus.wr1_data;
          rdBusyS[k]                  = 1'b0;
        end else if (wr0Hit && (bus.wr0_addr == rdAddrK[k])) begin
          rdDataS[k*DATA_W +: DATA_W] = bus.wr0_data;
        end else begin
          rdDataS[k*DATA_W +: DATA_W] = regs[rdAddrK[k]];
        end
`endif
      end
    end
  end

  assign bus.rd_data  = rdDataS;
  assign bus.rd_busy  = rdBusyS;
  assign bus.clr_busy = (state == SWEEP);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters, NUM_RD = 2).
// A behavioural model (value array, pending array, sweep countdown) predicts
// read data and busy flags; directed scenarios are followed by random traffic.
module tb_regfile_mp;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;

  logic [31:0] model [32];
  bit          sbM   [32];
  int          sweepLeft;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idleInputs();
    bus.rd_addr     = 10'd0;
    bus.wr0_en      = 1'b0;
    bus.wr0_addr    = 5'd0;
    bus.wr0_data    = 32'd0;
    bus.wr1_en      = 1'b0;
    bus.wr1_addr    = 5'd0;
    bus.wr1_data    = 32'd0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = 5'd0;
    bus.clr_req     = 1'b0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      model[i] = 32'd0;
      sbM[i]   = 1'b0;
    end
    sweepLeft = 0;
  endtask

  // Update the model with whatever is currently driven, then cross one edge.
  task automatic cycle();
    if (sweepLeft > 0) begin
      sweepLeft--;
      if (sweepLeft == 0) begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end
    end else begin
      if (bus.wr0_en && bus.wr0_addr != 5'd0) model[bus.wr0_addr] = bus.wr0_data;
      if (bus.wr1_en && bus.wr1_addr != 5'd0) model[bus.wr1_addr] = bus.wr1_data;
      if (bus.clr_req) begin
        for (int i = 0; i < 32; i++) sbM[i] = 1'b0;
        sweepLeft = 31;
      end else begin
        if (bus.wr1_en && bus.wr1_addr != 5'd0) sbM[bus.wr1_addr] = 1'b0;
        if (bus.sb_set_en && bus.sb_set_addr != 5'd0) sbM[bus.sb_set_addr] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] expData(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || sweepLeft > 0) return 32'd0;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr1_en && bus.wr1_addr == a) v = bus.wr1_data;
    else if (bus.wr0_en && bus.wr0_addr == a) v = bus.wr0_data;
`endif
    return v;
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    logic b;
    if (a == 5'd0 || sweepLeft > 0) return 1'b0;
    b = sbM[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr1_en && bus.wr1_addr == a) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic test_reset();
    idleInputs();
    reset = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    bus.rd_addr = {5'd17, 5'd3};
    #1;
    nChecks++;
    if (bus.clr_busy !== 1'b0) begin nFails++; $display("FAIL reset_clr_busy: got %b expected 0", bus.clr_busy); end
    nChecks++;
    if (bus.rd_data !== 64'd0) begin nFails++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    nChecks++;
    if (bus.rd_busy !== 2'b00) begin nFails++; $display("FAIL reset_rd_busy: got %b expected 00", bus.rd_busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    idleInputs();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEADBEEF;
    cycle();
    idleInputs();
    bus.rd_addr = {5'd5, 5'd5};
    #1;
    nChecks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin nFails++; $display("FAIL r5_port0: got %h expected deadbeef", bus.rd_data[31:0]); end
    nChecks++;
    if (bus.rd_data[63:32] !== 32'hDEADBEEF) begin nFails++; $display("FAIL r5_port1: got %h expected deadbeef", bus.rd_data[63:32]); end
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'h00001234;
    cycle();
    idleInputs();
    bus.rd_addr = {5'd0, 5'd0};
    #1;
    nChecks++;
    if (bus.rd_data !== 64'd0) begin nFails++; $display("FAIL r0_zero: got %h expected 0", bus.rd_data); end
  endtask

  task automatic test_collision();
    idleInputs();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11111111;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22222222;
    cycle();
    idleInputs();
    bus.rd_addr = {5'd0, 5'd7};
    #1;
    nChecks++;
    if (bus.rd_data[31:0] !== 32'h22222222) begin nFails++; $display("FAIL collision_r7: got %h expected 22222222", bus.rd_data[31:0]); end
  endtask

  task automatic test_scoreboard();
    idleInputs();
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
    cycle();
    idleInputs();
    bus.rd_addr = {5'd0, 5'd9};
    #1;
    nChecks++;
    if (bus.rd_busy !== 2'b01) begin nFails++; $display("FAIL sb_set_busy: got %b expected 01", bus.rd_busy); end
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h000000A5;
    cycle();
    idleInputs();
    bus.rd_addr = {5'd9, 5'd9};
    #1;
    nChecks++;
    if (bus.rd_busy !== 2'b11) begin nFails++; $display("FAIL sb_set_wins: got %b expected 11", bus.rd_busy); end
    nChecks++;
    if (bus.rd_data[31:0] !== 32'h000000A5) begin nFails++; $display("FAIL sb_wr1_data: got %h expected a5", bus.rd_data[31:0]); end
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h000000A6;
    cycle();
    idleInputs();
    bus.rd_addr = {5'd0, 5'd9};
    #1;
    nChecks++;
    if (bus.rd_busy !== 2'b00) begin nFails++; $display("FAIL sb_wr1_clear: got %b expected 00", bus.rd_busy); end
  endtask

  task automatic test_bypass();
    idleInputs();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h00001111;
    cycle();
    bus.wr0_data = 32'h0000CAFE;
    bus.rd_addr  = {5'd0, 5'd3};
    #1;
    nChecks++;
`ifdef REGFILE_BYPASS_EN
    if (bus.rd_data[31:0] !== 32'h0000CAFE) begin nFails++; $display("FAIL bypass_same_cycle: got %h expected cafe", bus.rd_data[31:0]); end
`else
    if (bus.rd_data[31:0] !== 32'h00001111) begin nFails++; $display("FAIL nobypass_same_cycle: got %h expected 1111", bus.rd_data[31:0]); end
`endif
    cycle();
    idleInputs();
    bus.rd_addr = {5'd0, 5'd3};
    #1;
    nChecks++;
    if (bus.rd_data[31:0] !== 32'h0000CAFE) begin nFails++; $display("FAIL bypass_next_cycle: got %h expected cafe", bus.rd_data[31:0]); end
  endtask

  task automatic fillAll();
    for (int i = 1; i < 32; i++) begin
      idleInputs();
      bus.wr0_en = 1'b1; bus.wr0_addr = 5'(i); bus.wr0_data = $urandom | 32'h1;
      cycle();
    end
    idleInputs();
  endtask

  task automatic test_sweep();
    int busyCycles;
    fillAll();
    bus.clr_req = 1'b1;
    cycle();
    busyCycles = 0;
    for (int c = 0; c < 40 && bus.clr_busy === 1'b1; c++) begin
      busyCycles++;
      bus.clr_req     = 1'($urandom_range(1));
      bus.rd_addr     = 10'($urandom);
      bus.wr0_en      = 1'b1; bus.wr0_addr = 5'($urandom_range(31, 1)); bus.wr0_data = $urandom | 32'h1;
      bus.wr1_en      = 1'b1; bus.wr1_addr = 5'($urandom_range(31, 1)); bus.wr1_data = $urandom | 32'h1;
      bus.sb_set_en   = 1'b1; bus.sb_set_addr = 5'($urandom_range(31, 1));
      #1;
      nChecks++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
        nFails++; $display("FAIL sweep_read_zero: got data %h busy %b expected 0/00", bus.rd_data, bus.rd_busy);
      end
      cycle();
    end
    nChecks++;
    if (busyCycles != 31) begin nFails++; $display("FAIL sweep_length: got %0d cycles expected 31", busyCycles); end
    idleInputs();
    for (int i = 1; i < 32; i += 2) begin
      bus.rd_addr = {5'(i + 1), 5'(i)};
      #1;
      nChecks++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
        nFails++; $display("FAIL sweep_after r%0d: got data %h busy %b expected 0/00", i, bus.rd_data, bus.rd_busy);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    fillAll();
    bus.clr_req = 1'b1;
    cycle();
    idleInputs();
    repeat (9) cycle();
    reset = 1'b0;
    modelReset();
    #1;
    nChecks++;
    if (bus.clr_busy !== 1'b0) begin nFails++; $display("FAIL midsweep_clr_busy: got %b expected 0", bus.clr_busy); end
    bus.rd_addr = {5'd31, 5'd20};
    #1;
    nChecks++;
    if (bus.rd_data !== 64'd0) begin nFails++; $display("FAIL midsweep_reads: got %h expected 0", bus.rd_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic [4:0] a;
    for (int c = 0; c < n; c++) begin
      bus.rd_addr     = {5'($urandom_range(7)), 5'($urandom_range(7))};
      bus.wr0_en      = 1'($urandom_range(1));
      bus.wr0_addr    = 5'($urandom_range(7));
      bus.wr0_data    = $urandom;
      bus.wr1_en      = 1'($urandom_range(1));
      bus.wr1_addr    = 5'($urandom_range(7));
      bus.wr1_data    = $urandom;
      bus.sb_set_en   = 1'($urandom_range(1));
      bus.sb_set_addr = 5'($urandom_range(7));
      bus.clr_req     = 1'b0;
      #1;
      for (int p = 0; p < 2; p++) begin
        a = bus.rd_addr[p*5 +: 5];
        nChecks++;
        if (bus.rd_data[p*32 +: 32] !== expData(a)) begin
          nFails++; $display("FAIL random_data port%0d r%0d: got %h expected %h", p, a, bus.rd_data[p*32 +: 32], expData(a));
        end
        nChecks++;
        if (bus.rd_busy[p] !== expBusy(a)) begin
          nFails++; $display("FAIL random_busy port%0d r%0d: got %b expected %b", p, a, bus.rd_busy[p], expBusy(a));
        end
      end
      cycle();
    end
    idleInputs();
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    reset   = 1'b0;
    idleInputs();
    modelReset();
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random(200);
    test_sweep();
    test_random(100);
    test_reset_mid_sweep();
    test_random(200);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
